// File: rtl/edge_pulse_decoder.sv
// rtl/edge_pulse_decoder.sv - rebuilds a level from transition pulses and queues {level, run length} records

// Small record queue: registered storage, head visible combinationally from the
// storage flops so it stays stable while the consumer stalls.
module edge_pulse_decoder_fifo #(
  parameter int DW = 9,
  parameter int DEPTH = 4,
  parameter logic [DW-1:0] INIT_WORD = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic                       full,
  output logic [DW-1:0]              head_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid     = (count != '0);
  assign full      = (count == FULL_CNT);
  assign head_data = mem[rd_ptr];

  // A pop frees the head slot in the same edge, so a full queue can still accept a push.
  assign do_pop  = valid && pop;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; clear empties the queue and restores the reset head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_WORD;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_WORD;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module edge_pulse_decoder #(
  parameter int   CNT_W      = 8,
  parameter int   FIFO_DEPTH = 4,
  parameter int   MIN_GAP    = 2,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pulse,
  input  logic                          clear,
  input  logic                          run_ready,
  output logic                          level,
  output logic                          run_valid,
  output logic                          run_level,
  output logic [CNT_W-1:0]              run_len,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          gap_err
);
  localparam int DW = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] GAP_MIN   = CNT_W'(MIN_GAP);
  localparam logic [DW-1:0]    INIT_WORD = {INIT_LEVEL, {CNT_W{1'b0}}};

  logic [CNT_W-1:0] cnt;
  logic             first;
  logic [CNT_W-1:0] cand_len;
  logic             gap_ok;
  logic             accept;
  logic             fifo_full;
  logic             fifo_pop;
  logic             drop;
  logic [DW-1:0]    head_data;

  // Length of the run ending at this edge, clamped so long idle periods never wrap.
  assign cand_len = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // The very first pulse after reset/clear has no previous pulse to be too close to.
  assign gap_ok = first || (cand_len >= GAP_MIN);
  assign accept = pulse && gap_ok;

  // A record is lost only when the queue is full and nothing leaves it this edge.
  assign fifo_pop = run_valid && run_ready;
  assign drop     = accept && fifo_full && !fifo_pop;

  assign run_level = head_data[DW-1];
  assign run_len   = head_data[CNT_W-1:0];

  // Level reconstruction, run-length counting and gap checking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= INIT_LEVEL;
      cnt     <= '0;
      first   <= 1'b1;
      gap_err <= 1'b0;
    end else if (clear) begin
      level   <= INIT_LEVEL;
      cnt     <= '0;
      first   <= 1'b1;
      gap_err <= 1'b0;
    end else if (accept) begin
      level <= ~level;
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      cnt <= cand_len;
      if (pulse) begin
        gap_err <= 1'b1;
      end
    end
  end

  // Sticky indication that a completed run could not be queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  edge_pulse_decoder_fifo #(
    .DW        (DW),
    .DEPTH     (FIFO_DEPTH),
    .INIT_WORD (INIT_WORD)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (accept),
    .push_data ({level, cand_len}),
    .pop       (run_ready),
    .valid     (run_valid),
    .full      (fifo_full),
    .head_data (head_data),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_edge_pulse_decoder.sv
// tb/tb_edge_pulse_decoder.sv - directed self-checking bench for edge_pulse_decoder

module tb_edge_pulse_decoder;
  logic       clk;
  logic       rst;
  logic       pulse;
  logic       clear;
  logic       run_ready;
  logic       level;
  logic       run_valid;
  logic       run_level;
  logic [7:0] run_len;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       gap_err;

  int checks = 0;
  int errors = 0;

  edge_pulse_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .pulse      (pulse),
    .clear      (clear),
    .run_ready  (run_ready),
    .level      (level),
    .run_valid  (run_valid),
    .run_level  (run_level),
    .run_len    (run_len),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .gap_err    (gap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive inputs at a falling edge; return at the next falling edge, after one rising edge.
  task automatic step(input logic p, input logic rdy);
    pulse     = p;
    run_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_clear(input logic p, input logic rdy);
    clear = 1'b1;
    step(p, rdy);
    clear = 1'b0;
  endtask

  // Pulses at relative edges 3, 6, 9, ...
  task automatic pulses_every3(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      step(1'b0, rdy);
      step(1'b0, rdy);
      step(1'b1, rdy);
    end
    pulse = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pulse = 1'b0; clear = 1'b0; run_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_valid", run_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_len", run_len, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_gap", gap_err, 0);
    rst = 1'b0;

    // Decode with ready: pulses at edges 3 and 8
    step(0, 1); step(0, 1); step(1, 1);
    chk("dec_level_e3", level, 1);
    chk("dec_valid_e3", run_valid, 1);
    chk("dec_rlevel_e3", run_level, 0);
    chk("dec_len_e3", run_len, 3);
    step(0, 1);
    chk("dec_valid_e4", run_valid, 0);
    step(0, 1); step(0, 1); step(0, 1); step(1, 1);
    chk("dec_level_e8", level, 0);
    chk("dec_valid_e8", run_valid, 1);
    chk("dec_rlevel_e8", run_level, 1);
    chk("dec_len_e8", run_len, 5);
    step(0, 1);
    chk("dec_valid_e9", run_valid, 0);

    // Gap: pulses at edges 4, 5 (rejected), 7 after clear
    do_clear(0, 1);
    step(0, 1); step(0, 1); step(0, 1); step(1, 1);
    chk("gap_level_e4", level, 1);
    chk("gap_len_e4", run_len, 4);
    chk("gap_err_e4", gap_err, 0);
    step(1, 1);
    chk("gap_level_e5", level, 1);
    chk("gap_err_e5", gap_err, 1);
    chk("gap_valid_e5", run_valid, 0);
    step(0, 1); step(1, 1);
    chk("gap_level_e7", level, 0);
    chk("gap_valid_e7", run_valid, 1);
    chk("gap_rlevel_e7", run_level, 1);
    chk("gap_len_e7", run_len, 3);
    step(0, 1);

    // Backpressure and overflow: five pulses, no consumer
    do_clear(0, 0);
    chk("clr_gap", gap_err, 0);
    pulses_every3(5, 0);
    chk("bp_count", fifo_count, 4);
    chk("bp_ovf", overflow, 1);
    chk("bp_level", level, 1);
    chk("bp_rlevel", run_level, 0);
    chk("bp_len", run_len, 3);
    step(0, 0);
    chk("bp_hold_len", run_len, 3);
    chk("bp_hold_count", fifo_count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", run_valid, 1);
      chk("drain_rlevel", run_level, i % 2);
      chk("drain_len", run_len, 3);
      step(0, 1);
    end
    chk("drain_empty", run_valid, 0);
    chk("drain_count", fifo_count, 0);
    chk("drain_ovf_sticky", overflow, 1);

    // Build two queued records with both flags set, then async reset mid-cycle
    do_clear(0, 0);
    pulses_every3(5, 0);
    step(1, 0);
    chk("pre_gap", gap_err, 1);
    step(0, 1); step(0, 1);
    run_ready = 1'b0;
    chk("pre_count", fifo_count, 2);
    chk("pre_ovf", overflow, 1);
    chk("pre_level", level, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", run_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_gap", gap_err, 0);
    chk("arst_len", run_len, 0);
    chk("arst_rlevel", run_level, 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation: 300 idle edges then a pulse
    for (int i = 0; i < 300; i++) step(0, 1);
    step(1, 1);
    chk("sat_valid", run_valid, 1);
    chk("sat_len", run_len, 255);
    chk("sat_rlevel", run_level, 0);
    chk("sat_level", level, 1);
    step(0, 1);

    // Full queue with push and pop on the same edge, then clear with a pulse
    do_clear(0, 0);
    pulses_every3(4, 0);
    chk("full_count", fifo_count, 4);
    chk("full_ovf", overflow, 0);
    step(0, 0); step(0, 0); step(1, 1);
    chk("pp_count", fifo_count, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_level", level, 1);
    chk("pp_rlevel", run_level, 1);
    chk("pp_len", run_len, 3);
    do_clear(1, 1);
    pulse = 1'b0;
    chk("clr_count", fifo_count, 0);
    chk("clr_level", level, 0);
    chk("clr_valid", run_valid, 0);
    chk("clr_len", run_len, 0);
    chk("clr_ovf", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
